// File: rtl/huffman_pkg.sv
// Shared JPEG Huffman definitions: FSM states, block geometry, special symbols
// and the coefficient-index to bit-offset mapping used by encode and decode.
package huffman_pkg;

    localparam int unsigned NUM_COEF = 64;
    localparam int unsigned PIX_W    = 8;
    localparam int unsigned BLOCK_W  = NUM_COEF * PIX_W;

    // {run, size} codes with special meaning
    localparam logic [7:0] EOB = 8'h00;
    localparam logic [7:0] ZRL = 8'hF0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_DC,
        ST_AC,
        ST_DONE,
        ST_ERR
    } dec_state_t;

    function automatic logic [8:0] coef_offset(input logic [5:0] idx);
        return 9'(idx) * 9'(PIX_W);
    endfunction

endpackage

// File: rtl/huffman_dec_controller_if.sv
// Symbol stream from the Huffman decoder into the block rebuild controller.
interface huffman_dec_controller_if;

    logic       sym_valid;
    logic       sym_ready;
    logic       sym_is_dc;
    logic [3:0] sym_run;
    logic [3:0] sym_size;
    logic [7:0] sym_value;

    modport master (
        output sym_valid, sym_is_dc, sym_run, sym_size, sym_value,
        input  sym_ready
    );

    modport slave (
        input  sym_valid, sym_is_dc, sym_run, sym_size, sym_value,
        output sym_ready
    );

endinterface

// File: rtl/huffman_dec_controller.sv
// Rebuilds a zigzag-ordered 64-coefficient block from decoded DC/AC symbols,
// keeping the DC predictor across blocks and trapping malformed streams.
module huffman_dec_controller
    import huffman_pkg::*;
(
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic                       block_start,
    input  logic                       dc_pred_clear,
    huffman_dec_controller_if.slave    sym,
    output logic [BLOCK_W-1:0]         zigzag_pix_out,
    output logic                       block_valid,
    output logic                       dec_error,
    output logic                       busy
);

    dec_state_t       state, next_state;
    logic [6:0]       pos, target, zrl_pos;
    logic [PIX_W-1:0] prev_dc, dc_sum;
    logic             handshake, can_start;
    logic             dc_write, ac_write, zrl_step;

    assign sym.sym_ready = (state == ST_DC) || (state == ST_AC);
    assign busy          = (state == ST_CLEAR) || (state == ST_DC) || (state == ST_AC);
    assign dec_error     = (state == ST_ERR);
    assign handshake     = sym.sym_valid && sym.sym_ready;
    assign can_start     = (state == ST_IDLE) || (state == ST_DONE);

    // 7-bit position arithmetic so runs past coefficient 63 are seen, not wrapped
    assign target  = pos + 7'(sym.sym_run);
    assign zrl_pos = pos + 7'd16;
    assign dc_sum  = prev_dc + sym.sym_value;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= ST_IDLE;
        else          state <= next_state;
    end

    always_comb begin
        next_state = state;
        dc_write   = 1'b0;
        ac_write   = 1'b0;
        zrl_step   = 1'b0;
        case (state)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (block_start) next_state = ST_CLEAR;
            end
            ST_CLEAR: next_state = ST_DC;
            ST_DC: begin
                if (handshake) begin
                    if (sym.sym_is_dc) begin
                        dc_write   = 1'b1;
                        next_state = ST_AC;
                    end else begin
                        next_state = ST_ERR;
                    end
                end
            end
            ST_AC: begin
                if (handshake) begin
                    if (sym.sym_is_dc) begin
                        next_state = ST_ERR;
                    end else if ({sym.sym_run, sym.sym_size} == EOB) begin
                        next_state = ST_DONE;
                    end else if ({sym.sym_run, sym.sym_size} == ZRL) begin
                        if (zrl_pos > 7'd63) next_state = ST_ERR;
                        else                 zrl_step   = 1'b1;
                    end else if (sym.sym_size == 4'd0) begin
                        next_state = ST_ERR;
                    end else if (target > 7'd63) begin
                        next_state = ST_ERR;
                    end else begin
                        ac_write = 1'b1;
                        if (target == 7'd63) next_state = ST_DONE;
                    end
                end
            end
            default: next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            zigzag_pix_out <= '0;
            pos            <= '0;
            prev_dc        <= '0;
            block_valid    <= 1'b0;
        end else begin
            block_valid <= (state == ST_AC) && (next_state == ST_DONE);

            // clear wins over the DC update; the two cannot coincide anyway
            if (can_start && dc_pred_clear) prev_dc <= '0;
            else if (dc_write)              prev_dc <= dc_sum;

            if (state == ST_CLEAR) begin
                zigzag_pix_out <= '0;
                pos            <= '0;
            end else if (dc_write) begin
                zigzag_pix_out[coef_offset(6'd0) +: PIX_W] <= dc_sum;
                pos <= 7'd1;
            end else if (zrl_step) begin
                pos <= zrl_pos;
            end else if (ac_write) begin
                zigzag_pix_out[coef_offset(target[5:0]) +: PIX_W] <= sym.sym_value;
                pos <= target + 7'd1;
            end
        end
    end

endmodule

// File: tb/tb_huffman_dec_controller.sv
// Self-checking bench: directed and randomized symbol streams against a
// coefficient-array reference model of the block rebuild rules.
module tb_huffman_dec_controller;
    import huffman_pkg::*;

    localparam int unsigned W = BLOCK_W;

    typedef struct packed {
        logic       is_dc;
        logic [3:0] run;
        logic [3:0] size;
        logic [7:0] value;
    } sym_t;

    logic           clock = 1'b0;
    logic           reset_n = 1'b0;
    logic           block_start = 1'b0;
    logic           dc_pred_clear = 1'b0;
    logic [W-1:0]   zigzag_pix_out;
    logic           block_valid;
    logic           dec_error;
    logic           busy;

    huffman_dec_controller_if sif();

    huffman_dec_controller dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .block_start    (block_start),
        .dc_pred_clear  (dc_pred_clear),
        .sym            (sif),
        .zigzag_pix_out (zigzag_pix_out),
        .block_valid    (block_valid),
        .dec_error      (dec_error),
        .busy           (busy)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc++;

    int   tests = 0;
    int   fails = 0;
    logic [7:0] pdc = 8'd0;
    bit   last_err = 1'b0;
    sym_t blk[$];

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic sym_t dc(input logic [7:0] v);
        return '{1'b1, 4'd0, 4'd0, v};
    endfunction

    function automatic sym_t ac(input logic [3:0] r, input logic [3:0] s, input logic [7:0] v);
        return '{1'b0, r, s, v};
    endfunction

    // Reference: walk the symbol list over a plain coefficient array.
    function automatic void model(input sym_t q[$], output logic [W-1:0] m,
                                  output bit err, output int n);
        byte unsigned coef[NUM_COEF];
        int pos;
        foreach (coef[k]) coef[k] = 0;
        err = 1'b0;
        n   = 0;
        pos = 0;
        for (int i = 0; i < q.size(); i++) begin
            n = i + 1;
            if (i == 0) begin
                if (!q[i].is_dc) begin err = 1'b1; break; end
                pdc     = pdc + q[i].value;
                coef[0] = pdc;
                pos     = 1;
                continue;
            end
            if (q[i].is_dc) begin err = 1'b1; break; end
            if (q[i].size == 0) begin
                if (q[i].run == 0) break;
                if (q[i].run == 15) begin
                    pos += 16;
                    if (pos > 63) begin err = 1'b1; break; end
                    continue;
                end
                err = 1'b1;
                break;
            end
            pos += int'(q[i].run);
            if (pos > 63) begin err = 1'b1; break; end
            coef[pos] = q[i].value;
            pos++;
            if (pos == NUM_COEF) break;
        end
        m = '0;
        for (int k = 0; k < NUM_COEF; k++)
            m = m | (W'(coef[k]) << (k * PIX_W));
    endfunction

    task automatic send_one(input sym_t s, input bit gaps, output bit ok);
        int guard;
        guard = 0;
        ok    = 1'b0;
        if (gaps) begin
            repeat ($urandom_range(0, 2)) begin
                sif.sym_valid = 1'b0;
                sif.sym_value = 8'($urandom);
                @(posedge clock); #1;
            end
        end
        sif.sym_valid = 1'b1;
        sif.sym_is_dc = s.is_dc;
        sif.sym_run   = s.run;
        sif.sym_size  = s.size;
        sif.sym_value = s.value;
        while (!ok && guard < 20) begin
            @(negedge clock);
            ok = sif.sym_ready;
            @(posedge clock); #1;
            guard++;
        end
        sif.sym_valid = 1'b0;
    endtask

    task automatic start_block(input bit clr);
        block_start   = 1'b1;
        dc_pred_clear = clr;
        @(posedge clock); #1;
        block_start   = 1'b0;
        dc_pred_clear = 1'b0;
        check("busy_clear",  W'(busy), W'(1));
        check("err_cleared", W'(dec_error), W'(0));
        check("ready_clear", W'(sif.sym_ready), W'(0));
    endtask

    task automatic run_block(input sym_t q[$], input bit gaps, input bit clr);
        logic [W-1:0] exp;
        bit err, ok;
        int n, t0;
        if (clr && !last_err) pdc = 8'd0;
        model(q, exp, err, n);
        t0 = cyc;
        start_block(clr);
        for (int i = 0; i < n; i++) begin
            send_one(q[i], gaps, ok);
            if (!ok) begin
                check("hs_timeout", W'(0), W'(1));
                last_err = err;
                return;
            end
        end
        check("block_valid", W'(block_valid), W'(!err));
        check("dec_error",   W'(dec_error), W'(err));
        check("busy_end",    W'(busy), W'(0));
        check("ready_end",   W'(sif.sym_ready), W'(0));
        if (!err) check("matrix", zigzag_pix_out, exp);
        if (!err && !gaps) check("latency", W'(cyc - t0), W'(2 + n));
        @(posedge clock); #1;
        check("bv_pulse", W'(block_valid), W'(0));
        if (!err) check("matrix_hold", zigzag_pix_out, exp);
        last_err = err;
    endtask

    task automatic gen_block();
        int r;
        blk.delete();
        if ($urandom_range(0, 19) == 0) blk.push_back(ac(4'd0, 4'd1, 8'($urandom)));
        else                            blk.push_back(dc(8'($urandom)));
        repeat ($urandom_range(0, 10)) begin
            r = $urandom_range(0, 19);
            if (r < 2)       blk.push_back(ac(4'd15, 4'd0, 8'd0));
            else if (r == 2) blk.push_back(($urandom_range(0, 1) == 1) ? dc(8'($urandom))
                                          : ac(4'($urandom_range(1, 14)), 4'd0, 8'd0));
            else             blk.push_back(ac(4'($urandom_range(0, 7)), 4'($urandom_range(1, 10)),
                                              8'($urandom)));
        end
        blk.push_back(ac(4'd0, 4'd0, 8'd0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        sif.sym_valid = 1'b0;
        sif.sym_is_dc = 1'b0;
        sif.sym_run   = 4'd0;
        sif.sym_size  = 4'd0;
        sif.sym_value = 8'd0;
        repeat (3) @(posedge clock);
        #1;
        check("rst_matrix", zigzag_pix_out, '0);
        check("rst_bvalid", W'(block_valid), W'(0));
        check("rst_error",  W'(dec_error), W'(0));
        check("rst_busy",   W'(busy), W'(0));
        check("rst_ready",  W'(sif.sym_ready), W'(0));
        reset_n = 1'b1;
        @(posedge clock); #1;

        blk = '{dc(8'd5), ac(4'd0, 4'd0, 8'd0)};
        run_block(blk, 1'b0, 1'b0);
        check("dc_only_coef0", W'(zigzag_pix_out[7:0]), W'(8'd5));

        blk = '{dc(8'hFD), ac(4'd2, 4'd3, 8'd7), ac(4'd0, 4'd0, 8'd0)};
        run_block(blk, 1'b0, 1'b0);
        check("second_coef0", W'(zigzag_pix_out[7:0]), W'(8'd2));
        check("second_coef3", W'(zigzag_pix_out[31:24]), W'(8'd7));

        blk = '{dc(8'd0), ac(4'd15, 4'd0, 8'd0), ac(4'd15, 4'd0, 8'd0), ac(4'd15, 4'd0, 8'd0),
                ac(4'd13, 4'd1, 8'd1), ac(4'd0, 4'd1, 8'hFF)};
        run_block(blk, 1'b0, 1'b0);
        check("zrl_coef62", W'(zigzag_pix_out[503:496]), W'(8'd1));
        check("zrl_coef63", W'(zigzag_pix_out[511:504]), W'(8'hFF));

        blk = '{dc(8'd1), ac(4'd15, 4'd0, 8'd0), ac(4'd15, 4'd0, 8'd0), ac(4'd15, 4'd0, 8'd0),
                ac(4'd15, 4'd0, 8'd0), ac(4'd0, 4'd0, 8'd0)};
        run_block(blk, 1'b0, 1'b0);
        repeat (3) @(posedge clock);
        #1;
        check("err_sticky", W'(dec_error), W'(1));

        blk = '{ac(4'd0, 4'd1, 8'd3), ac(4'd0, 4'd0, 8'd0)};
        run_block(blk, 1'b0, 1'b0);
        blk = '{dc(8'd1), ac(4'd0, 4'd1, 8'd2), dc(8'd3), ac(4'd0, 4'd0, 8'd0)};
        run_block(blk, 1'b0, 1'b0);
        blk = '{dc(8'd1), ac(4'd5, 4'd0, 8'd0), ac(4'd0, 4'd0, 8'd0)};
        run_block(blk, 1'b0, 1'b0);

        blk = '{dc(8'd9), ac(4'd0, 4'd0, 8'd0)};
        run_block(blk, 1'b0, 1'b0);
        blk = '{dc(8'd4), ac(4'd1, 4'd2, 8'h80), ac(4'd0, 4'd0, 8'd0)};
        run_block(blk, 1'b0, 1'b1);

        for (int b = 0; b < 40; b++) begin
            gen_block();
            run_block(blk, 1'b1, ($urandom_range(0, 3) == 0));
        end

        start_block(1'b0);
        send_one(dc(8'h33), 1'b0, ok);
        send_one(ac(4'd1, 4'd2, 8'h44), 1'b0, ok);
        check("pre_reset_busy", W'(busy), W'(1));
        #2 reset_n = 1'b0;
        #1;
        check("mid_rst_matrix", zigzag_pix_out, '0);
        check("mid_rst_busy",   W'(busy), W'(0));
        check("mid_rst_ready",  W'(sif.sym_ready), W'(0));
        check("mid_rst_bvalid", W'(block_valid), W'(0));
        check("mid_rst_error",  W'(dec_error), W'(0));
        @(posedge clock); #1;
        reset_n  = 1'b1;
        pdc      = 8'd0;
        last_err = 1'b0;
        @(posedge clock); #1;
        blk = '{dc(8'h21), ac(4'd0, 4'd0, 8'd0)};
        run_block(blk, 1'b0, 1'b0);
        check("post_rst_dc", W'(zigzag_pix_out[7:0]), W'(8'h21));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
